// File: rtl/pipe_wb_port_arbiter_if.sv
// Write-back port bundle between the MEM/WB stage, the long-latency unit, the
// hazard unit and the register file. The slave side is the arbiter.
interface pipe_wb_port_arbiter_if;
  logic        wwreg;
  logic [4:0]  wrn;
  logic [31:0] wdata;
  logic        lvalid;
  logic [4:0]  lrn;
  logic [31:0] ldata;
  logic        lready;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        stall;
  logic [4:0]  chk_rn;
  logic        pend_hit;

  modport master (
    output wwreg, wrn, wdata, lvalid, lrn, ldata, chk_rn,
    input  lready, rf_we, rf_wn, rf_d, stall, pend_hit
  );

  modport slave (
    input  wwreg, wrn, wdata, lvalid, lrn, ldata, chk_rn,
    output lready, rf_we, rf_wn, rf_d, stall, pend_hit
  );
endinterface

// File: rtl/pipe_wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline WB has priority, LLU results queue in a FIFO
// and drain into free slots; starvation forces a stall slot. WBARB_BYPASS_EN enables idle bypass.
module pipe_wb_port_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  clrn,
  pipe_wb_port_arbiter_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [7:0]    AGE_LIM = 8'(STARVE_MAX - 1);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  logic [4:0]    rn_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [7:0]    age_q,    age_d;
  logic [0:0]    state_q,  state_d;
  logic          rf_we_q,  rf_we_d;
  logic [4:0]    rf_wn_q,  rf_wn_d;
  logic [31:0]   rf_d_q,   rf_d_d;

  logic          force_slot;
  logic          fifo_empty;
  logic          lready;
  logic          pipe_take;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          pend_hit;
  logic [PW-1:0] offs;

  always_comb begin
    force_slot = (state_q == ST_FORCE);
    fifo_empty = (count_q == '0);
    lready     = (count_q != FULL);
    // A forced slot belongs to the FIFO head; the pipeline write is held by stall.
    pipe_take  = !force_slot && bus.wwreg && (bus.wrn != '0);
    pop        = !fifo_empty && (force_slot || !pipe_take);
`ifdef WBARB_BYPASS_EN
    bypass     = !force_slot && fifo_empty && !pipe_take && bus.lvalid && (bus.lrn != '0);
`else
    bypass     = 1'b0;
`endif
    // r0 results are accepted but never queued.
    push       = bus.lvalid && lready && (bus.lrn != '0) && !bypass;
  end

  always_comb begin
    rf_we_d = 1'b0;
    rf_wn_d = rf_wn_q;
    rf_d_d  = rf_d_q;
    if (pipe_take) begin
      rf_we_d = 1'b1;
      rf_wn_d = bus.wrn;
      rf_d_d  = bus.wdata;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_wn_d = rn_mem[rd_ptr_q];
      rf_d_d  = data_mem[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d = 1'b1;
      rf_wn_d = bus.lrn;
      rf_d_d  = bus.ldata;
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + 8'd1;
    end

    state_d = ST_NORMAL;
    if (state_q == ST_NORMAL && !fifo_empty && !pop && age_q == AGE_LIM) begin
      state_d = ST_FORCE;
    end
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    pend_hit = 1'b0;
    offs     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ((CW'(offs) < count_q) && (rn_mem[i] == bus.chk_rn)) begin
        pend_hit = 1'b1;
      end
    end
    if (bus.chk_rn == '0) begin
      pend_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      state_q  <= ST_NORMAL;
      rf_we_q  <= 1'b0;
      rf_wn_q  <= '0;
      rf_d_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      state_q  <= state_d;
      rf_we_q  <= rf_we_d;
      rf_wn_q  <= rf_wn_d;
      rf_d_q   <= rf_d_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rn_mem[wr_ptr_q]   <= bus.lrn;
      data_mem[wr_ptr_q] <= bus.ldata;
    end
  end

  assign bus.lready   = lready;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_wn    = rf_wn_q;
  assign bus.rf_d     = rf_d_q;
  assign bus.stall    = (state_q == ST_FORCE);
  assign bus.pend_hit = pend_hit;

endmodule

// File: tb/tb_pipe_wb_port_arbiter.sv
// Directed bench for pipe_wb_port_arbiter: stimulus pushes expected regfile writes
// (register, data, cycle) into a scoreboard; a negedge monitor pops and compares.
module tb_pipe_wb_port_arbiter;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  int   cyc  = 0;

  pipe_wb_port_arbiter_if bus ();

  pipe_wb_port_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rn;
    int data;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_wr(input int rn, input int data, input int at);
    sb.push_back('{rn, data, at});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wwreg  = 1'b0;
    bus.wrn    = '0;
    bus.wdata  = '0;
    bus.lvalid = 1'b0;
    bus.lrn    = '0;
    bus.ldata  = '0;
  endtask

  task automatic drive_pipe(input int rn, input int data);
    bus.wwreg = 1'b1;
    bus.wrn   = 5'(rn);
    bus.wdata = 32'(data);
  endtask

  task automatic drive_llu(input int rn, input int data);
    bus.lvalid = 1'b1;
    bus.lrn    = 5'(rn);
    bus.ldata  = 32'(data);
  endtask

  // Monitor: every regfile write must match the oldest expectation, in its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      if (bus.rf_we) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write (cycle %0d)",
                   bus.rf_wn, bus.rf_d, cyc);
        end else begin
          e = sb.pop_front();
          check("wb_rn",    int'(bus.rf_wn), e.rn);
          check("wb_data",  int'(bus.rf_d),  e.data);
          check("wb_cycle", cyc,             e.at);
        end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        $display("FAIL missed_write: got no write, expected r%0d=0x%0h at cycle %0d (cycle %0d)",
                 e.rn, e.data, e.at, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int p;
    idle_inputs();
    bus.chk_rn = 5'd5;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b0;
    check("rst_rf_we",    int'(bus.rf_we),    0);
    check("rst_lready",   int'(bus.lready),   1);
    check("rst_stall",    int'(bus.stall),    0);
    check("rst_pend_hit", int'(bus.pend_hit), 0);
    step();

    // Pipeline and LLU in the same cycle: pipeline first, queued result next slot.
    step();
    base = cyc;
    drive_pipe(5, 32'h11);
    drive_llu(7, 32'h22);
    expect_wr(5, 32'h11, base + 1);
    expect_wr(7, 32'h22, base + 2);
    step();
    idle_inputs();
    repeat (3) step();

    // Fill the FIFO under continuous pipeline writes; fifth result waits for space.
    base = cyc;
    for (int t = 0; t < 12; t++) begin
      idle_inputs();
      if (t <= 5) begin
        drive_pipe(20 + t, 32'h300 + t);
        expect_wr(20 + t, 32'h300 + t, base + t + 1);
      end
      if (t <= 3) drive_llu(16 + t, 32'h100 + t);
      else if (t <= 7) drive_llu(15, 32'h105);
      if (t >= 6 && t <= 9) expect_wr(10 + t, 32'h100 + t - 6, base + t + 1);
      if (t == 10) expect_wr(15, 32'h105, base + 11);
      #1;
      if (t <= 7) check($sformatf("fill_lready_t%0d", t), int'(bus.lready), (t <= 3 || t == 7) ? 1 : 0);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Starvation: one queued r9 entry under a pipeline writing every cycle.
    base = cyc;
    bus.chk_rn = 5'd9;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      if (k == 0) drive_llu(9, 32'h99);
      p = (k <= 9) ? k : k - 1;
      drive_pipe(20 + p, 32'h4000 + p);
      if (k == 9) expect_wr(9, 32'h99, base + 10);
      if (k != 10) expect_wr(20 + p, 32'h4000 + p, (p <= 8) ? base + p + 1 : base + p + 2);
      if (k >= 1) check($sformatf("starve_stall_k%0d", k), int'(bus.stall), (k == 9) ? 1 : 0);
      if (k == 1) begin
        #1 check("pend_hit_r9", int'(bus.pend_hit), 1);
        bus.chk_rn = 5'd0;
        #1 check("pend_hit_r0", int'(bus.pend_hit), 0);
        bus.chk_rn = 5'd9;
      end
      if (k == 8) begin
        #1 check("pend_hit_waiting", int'(bus.pend_hit), 1);
      end
      if (k == 10) begin
        #1 check("pend_hit_drained", int'(bus.pend_hit), 0);
      end
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Idle pipeline LLU latency, then r0 results and r0 pipeline writes.
    base = cyc;
    bus.chk_rn = 5'd3;
    drive_llu(3, 32'hABCD);
`ifdef WBARB_BYPASS_EN
    expect_wr(3, 32'hABCD, base + 1);
`else
    expect_wr(3, 32'hABCD, base + 2);
`endif
    step();
    idle_inputs();
    #1;
`ifdef WBARB_BYPASS_EN
    check("llu_pend_hit", int'(bus.pend_hit), 0);
`else
    check("llu_pend_hit", int'(bus.pend_hit), 1);
`endif
    repeat (2) step();
    drive_llu(0, 32'hDEAD);
    step();
    idle_inputs();
    drive_pipe(0, 32'hBEEF);
    step();
    idle_inputs();
    repeat (3) step();

    // Asynchronous reset with three results queued: queued writes are discarded.
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      drive_pipe(1 + k, 32'h500 + k);
      drive_llu(10 + k, 32'h600 + k);
      expect_wr(1 + k, 32'h500 + k, base + k + 1);
      step();
    end
    idle_inputs();
    bus.chk_rn = 5'd10;
    #1;
    check("pre_rst_lready",   int'(bus.lready),   1);
    check("pre_rst_pend_hit", int'(bus.pend_hit), 1);
    @(negedge clk);
    #1 clrn = 1'b1;
    #1;
    check("mid_rst_rf_we",    int'(bus.rf_we),    0);
    check("mid_rst_lready",   int'(bus.lready),   1);
    check("mid_rst_stall",    int'(bus.stall),    0);
    check("mid_rst_pend_hit", int'(bus.pend_hit), 0);
    step();
    check("post_rst_rf_we", int'(bus.rf_we), 0);
    clrn = 1'b0;
    repeat (6) step();
    check("post_rst_pend_hit", int'(bus.pend_hit), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
